// File: rtl/ntt_butterfly_pe.sv
// Modular CT/GS butterfly for NTT/INTT with a runtime twiddle and Barrett reduction mod Q.
// Latency 4 cycles, 1 item/clk; whole pipe holds while valid_out & ~out_ready (in_ready low).
module ntt_butterfly_pe #(
   parameter int W = 12,
   parameter int Q = 3329
) (
   input  logic         clk,
   input  logic         r,
   input  logic         valid_in,
   output logic         in_ready,
   input  logic         mode,
   input  logic [W-1:0] IN_1,
   input  logic [W-1:0] IN_2,
   input  logic [W-1:0] TW,
   output logic         valid_out,
   input  logic         out_ready,
   output logic [W-1:0] U,
   output logic [W-1:0] V
);
   localparam int K  = 2 * W;
   localparam int W2 = 2 * W;
   localparam int PW = W2 + K + 1;
   localparam logic [K:0]    TWO_K = (K+1)'(1) << K;
   localparam logic [K:0]    M     = TWO_K / (K+1)'(Q);
   localparam logic [W:0]    Q_W1  = (W+1)'(Q);
   localparam logic [W+1:0]  Q_W2  = (W+2)'(Q);
   localparam logic [W2-1:0] Q_P   = W2'(Q);

   function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] t;
      t = {1'b0, x} + {1'b0, y};
      if (t >= Q_W1) t = t - Q_W1;
      return t[W-1:0];
   endfunction

   // Borrow lands in bit W because |x-y| < 2**W.
   function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] t;
      t = {1'b0, x} - {1'b0, y};
      if (t[W]) t = t + Q_W1;
      return t[W-1:0];
   endfunction

   logic stall;
   assign stall    = valid_out & ~out_ready;
   assign in_ready = ~stall;

   logic          s1_vld, s1_mode;
   logic [W-1:0]  s1_a, s1_b, s1_w, s1_s, s1_d;
   logic          s2_vld, s2_mode;
   logic [W-1:0]  s2_a, s2_s;
   logic [W2-1:0] s2_p;
   logic          s3_vld, s3_mode;
   logic [W-1:0]  s3_a, s3_s, s3_x;

   // Barrett quotient estimate undershoots by at most 2, hence two corrections.
   logic [W2-1:0] t3;
   logic [W+1:0]  x3;
   always_comb begin
      t3 = W2'((PW'(s2_p) * PW'(M)) >> K);
      x3 = (W+2)'(s2_p - t3 * Q_P);
      if (x3 >= Q_W2) x3 = x3 - Q_W2;
      if (x3 >= Q_W2) x3 = x3 - Q_W2;
   end

   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         s1_vld  <= 1'b0;
         s1_mode <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_w    <= '0;
         s1_s    <= '0;
         s1_d    <= '0;
         s2_vld  <= 1'b0;
         s2_mode <= 1'b0;
         s2_a    <= '0;
         s2_s    <= '0;
         s2_p    <= '0;
         s3_vld  <= 1'b0;
         s3_mode <= 1'b0;
         s3_a    <= '0;
         s3_s    <= '0;
         s3_x    <= '0;
         valid_out <= 1'b0;
         U       <= '0;
         V       <= '0;
      end else if (!stall) begin
         s1_vld  <= valid_in;
         s1_mode <= mode;
         s1_a    <= IN_1;
         s1_b    <= IN_2;
         s1_w    <= TW;
         s1_s    <= mod_add(IN_1, IN_2);
         s1_d    <= mod_sub(IN_1, IN_2);

         s2_vld  <= s1_vld;
         s2_mode <= s1_mode;
         s2_a    <= s1_a;
         s2_s    <= s1_s;
         s2_p    <= W2'(s1_w) * W2'(s1_mode ? s1_d : s1_b);

         s3_vld  <= s2_vld;
         s3_mode <= s2_mode;
         s3_a    <= s2_a;
         s3_s    <= s2_s;
         s3_x    <= W'(x3);

         valid_out <= s3_vld;
         // Outputs only move for real items, so bubbles leave U/V untouched.
         if (s3_vld) begin
            U <= s3_mode ? s3_s : mod_add(s3_a, s3_x);
            V <= s3_mode ? s3_x : mod_sub(s3_a, s3_x);
         end
      end
   end
endmodule

// File: tb/tb_ntt_butterfly_pe.sv
// Bench for ntt_butterfly_pe: a Kyber and a Dilithium instance share control and are
// checked every cycle against a modular-arithmetic reference plus directed literal vectors.
module tb_ntt_butterfly_pe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        r, valid_in, mode, out_ready;
   logic        in_ready0, valid_out0, in_ready1, valid_out1;
   logic [11:0] a0, b0, w0, u0, v0;
   logic [22:0] a1, b1, w1, u1, v1;

   int n_cmp = 0;
   int n_bad = 0;
   bit rnd_ordy = 1'b0;

   ntt_butterfly_pe #(.W(12), .Q(3329)) dut_k (
      .clk(clk), .r(r), .valid_in(valid_in), .in_ready(in_ready0), .mode(mode),
      .IN_1(a0), .IN_2(b0), .TW(w0), .valid_out(valid_out0), .out_ready(out_ready),
      .U(u0), .V(v0));

   ntt_butterfly_pe #(.W(23), .Q(8380417)) dut_d (
      .clk(clk), .r(r), .valid_in(valid_in), .in_ready(in_ready1), .mode(mode),
      .IN_1(a1), .IN_2(b1), .TW(w1), .valid_out(valid_out1), .out_ready(out_ready),
      .U(u1), .V(v1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
      end
   endtask

   // Reference butterfly straight from the modular definitions.
   function automatic void model(input bit m, input longint q, input longint a, input longint b,
                                 input longint w, output longint u, output longint v);
      longint x;
      if (!m) begin
         x = (w * b) % q;
         u = (a + x) % q;
         v = (a - x + q) % q;
      end else begin
         u = (a + b) % q;
         v = (w * ((a - b + q) % q)) % q;
      end
   endfunction

   typedef struct {
      longint eu0, ev0, eu1, ev1;
      longint due;
   } exp_t;

   exp_t   sbq[$];
   longint adv = 0;
   int     n_out = 0;
   bit     e_vld, e_stall;
   exp_t   e;

   // adv counts clock edges on which the pipe may advance; an item accepted with adv=n
   // must be presented once adv reaches n+4 and stays presented until taken.
   always @(negedge clk) begin
      if (!r) begin
         chk("rst valid_out0", valid_out0, 0);
         chk("rst valid_out1", valid_out1, 0);
         chk("rst in_ready0", in_ready0, 1);
         chk("rst U0", u0, 0);
         chk("rst V0", v0, 0);
         chk("rst U1", u1, 0);
         chk("rst V1", v1, 0);
         sbq.delete();
      end else begin
         e_vld   = (sbq.size() > 0) && (sbq[0].due == adv);
         e_stall = e_vld && !out_ready;
         chk("valid_out0", valid_out0, e_vld);
         chk("valid_out1", valid_out1, e_vld);
         chk("in_ready0", in_ready0, !e_stall);
         chk("in_ready1", in_ready1, !e_stall);
         if (e_vld) begin
            chk("U0", u0, sbq[0].eu0);
            chk("V0", v0, sbq[0].ev0);
            chk("U1", u1, sbq[0].eu1);
            chk("V1", v1, sbq[0].ev1);
            if (out_ready) begin
               void'(sbq.pop_front());
               n_out++;
            end
         end
         if (valid_in && !e_stall) begin
            model(mode, 3329, longint'(a0), longint'(b0), longint'(w0), e.eu0, e.ev0);
            model(mode, 8380417, longint'(a1), longint'(b1), longint'(w1), e.eu1, e.ev1);
            e.due = adv + 4;
            sbq.push_back(e);
         end
         if (!e_stall) adv++;
      end
   end

   task automatic send(input bit m, input logic [11:0] xa0, input logic [11:0] xb0,
                       input logic [11:0] xw0, input logic [22:0] xa1, input logic [22:0] xb1,
                       input logic [22:0] xw1);
      bit ok = 1'b0;
      mode = m;
      a0 = xa0; b0 = xb0; w0 = xw0;
      a1 = xa1; b1 = xb1; w1 = xw1;
      valid_in = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
         #1;
         ok = in_ready0;
         @(posedge clk);
         #1;
      end
      chk("send accepted", ok, 1);
   endtask

   task automatic send_rand(input bit m);
      send(m, 12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)),
           12'($urandom_range(0, 3328)), 23'($urandom_range(0, 8380416)),
           23'($urandom_range(0, 8380416)), 23'($urandom_range(0, 8380416)));
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) begin
         if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      valid_in  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 60 && sbq.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain empty", sbq.size(), 0);
   endtask

   task automatic single(input bit m, input logic [11:0] xa0, input logic [11:0] xb0,
                         input logic [11:0] xw0, input logic [22:0] xa1, input logic [22:0] xb1,
                         input logic [22:0] xw1, input int eu0, input int ev0, input int eu1,
                         input int ev1, input string nm);
      int lat;
      send(m, xa0, xb0, xw0, xa1, xb1, xw1);
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out0 && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, lat, 4);
      chk({nm, " U0"}, u0, eu0);
      chk({nm, " V0"}, v0, ev0);
      chk({nm, " U1"}, u1, eu1);
      chk({nm, " V1"}, v1, ev1);
      idle(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      longint mu, mv;
      int     begin_out;
      r = 1'b1; valid_in = 1'b0; mode = 1'b0; out_ready = 1'b1;
      a0 = '0; b0 = '0; w0 = '0; a1 = '0; b1 = '0; w1 = '0;
      #2 r = 1'b0;
      #1;
      chk("init valid_out0", valid_out0, 0);
      chk("init in_ready0", in_ready0, 1);
      chk("init U0", u0, 0);
      chk("init V1", v1, 0);

      model(0, 3329, 5, 7, 17, mu, mv);
      chk("model ct U", mu, 124);
      chk("model ct V", mv, 3215);
      model(1, 3329, 5, 7, 17, mu, mv);
      chk("model gs U", mu, 12);
      chk("model gs V", mv, 3295);
      model(0, 8380417, 0, 1, 1753, mu, mv);
      chk("model dil U", mu, 1753);
      chk("model dil V", mv, 8378664);

      @(posedge clk);
      @(posedge clk);
      #1 r = 1'b1;
      idle(2);

      single(0, 5, 7, 17, 0, 1, 1753, 124, 3215, 1753, 8378664, "ct basic");
      single(1, 5, 7, 17, 5, 7, 17, 12, 3295, 12, 8380383, "gs basic");
      single(0, 3328, 3328, 3328, 8380416, 8380416, 8380416, 0, 3327, 0, 8380415, "ct max");
      single(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "ct zero");

      begin_out = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand(1'($urandom_range(0, 1)));
            valid_in = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            chk("stall in_ready", in_ready0, 0);
            chk("stall valid_out", valid_out0, 1);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stream count", n_out - begin_out, 8);

      rnd_ordy  = 1'b1;
      begin_out = n_out;
      for (int i = 0; i < 1000; i++) begin
         send_rand(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rnd_ordy = 1'b0;
      drain();
      chk("random count", n_out - begin_out, 1000);

      out_ready = 1'b1;
      idle(2);
      for (int i = 0; i < 3; i++) send_rand(1'b0);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-reset valid_out", valid_out0, 1);
      r = 1'b0;
      #1;
      chk("async rst valid_out0", valid_out0, 0);
      chk("async rst valid_out1", valid_out1, 0);
      chk("async rst U0", u0, 0);
      chk("async rst V0", v0, 0);
      chk("async rst U1", u1, 0);
      chk("async rst V1", v1, 0);
      @(posedge clk);
      @(posedge clk);
      #1 r = 1'b1;
      idle(8);
      chk("post-reset idle", valid_out0, 0);
      single(0, 3328, 3328, 3328, 8380416, 8380416, 8380416, 0, 3327, 0, 8380415, "after reset");
      chk("final queue", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
